slave_arbiter: RTL

Round-robin arbiter that shares one 32-bit slave port among four requesters. It drives the 2-bit select of the 4:1 slave-side data mux and a one-hot grant vector, and holds each grant until the slave acknowledges the transaction or a watchdog timeout expires. It sits between the SIMD lane/master request logic and the slave data mux in the DLX memory/peripheral path.

---
 rtl/slave_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/slave_arbiter.sv
// ---------------------------------------------------------------------------
// slave_arbiter
//
// Round-robin arbiter sharing one 32-bit slave port among four requesters.
// It drives the select of the slave-side 4:1 data mux and a one-hot grant.
// Each grant is held until the slave acknowledges, or until a watchdog
// revokes it after TIMEOUT_CYCLES busy cycles.
//
// Parameters:
//   TIMEOUT_CYCLES : busy cycles without SLAVE_ACK before the grant is
//                    revoked (0 disables the watchdog)
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   REQ[3:0]    in   level requests; bit i is mux input i (A..D)
//   SLAVE_ACK   in   one-cycle completion strobe from the slave
//   GNT[3:0]    out  one-hot grant, zero while idle
//   SEL_MUX[1:0]out  index of the granted requester (held through idle)
//   SLAVE_REQ   out  transaction strobe, high in every busy cycle
//   BUSY        out  high while a grant is held
//   TIMEOUT_ERR out  one-cycle pulse after a watchdog revocation
//   ERR_ID[1:0] out  requester that last timed out
// ---------------------------------------------------------------------------
module slave_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    input  logic       SLAVE_ACK,
    output logic [3:0] GNT,
    output logic [1:0] SEL_MUX,
    output logic       SLAVE_REQ,
    output logic       BUSY,
    output logic       TIMEOUT_ERR,
    output logic [1:0] ERR_ID
);

    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic             r_sreq;
    logic             r_busy;
    logic             r_terr;
    logic [1:0]       r_err_id;

    logic [1:0]       w_pick;
    logic             w_timeout;

    // Round-robin pick: first set request scanning ptr, ptr+1, ... mod 4.
    // Scanning from the farthest offset down lets the nearest one win last.
    function automatic logic [1:0] f_rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign w_pick    = f_rr_pick(REQ, r_ptr);
    // Counter holds (number of completed busy cycles); the last allowed
    // busy cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_cnt    <= '0;
            r_gnt    <= 4'b0000;
            r_sel    <= 2'd0;
            r_sreq   <= 1'b0;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
            r_err_id <= 2'd0;
        end else begin
            // Error flag is a single-cycle pulse unless re-armed below.
            r_terr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // SLAVE_ACK is deliberately not looked at here.
                    if (|REQ) begin
                        r_state <= ST_BUSY;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_sel   <= w_pick;
                        r_busy  <= 1'b1;
                        r_sreq  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_gnt   <= 4'b0000;
                    end
                end
                ST_BUSY: begin
                    // Saturating count so it can never wrap back to the limit.
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                    if (SLAVE_ACK || w_timeout) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_sreq  <= 1'b0;
                        r_ptr   <= r_sel + 2'd1;
                        // ACK takes precedence over a coincident timeout.
                        if (!SLAVE_ACK) begin
                            r_terr   <= 1'b1;
                            r_err_id <= r_sel;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign GNT         = r_gnt;
    assign SEL_MUX     = r_sel;
    assign SLAVE_REQ   = r_sreq;
    assign BUSY        = r_busy;
    assign TIMEOUT_ERR = r_terr;
    assign ERR_ID      = r_err_id;

endmodule
